// File: rtl/data_ram_pkg.sv
// Shared defaults, state encoding and word/address types for the data-RAM responder.
package data_ram_pkg;
  localparam int DEF_SIZE       = 32;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_DEPTH      = 1024;
  localparam int DEF_CNT_WIDTH  = 16;

  typedef enum logic {S_CLEAR, S_READY} ram_state_t;

  typedef logic [DEF_SIZE-1:0]       word_t;
  typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;

  // Array index width; a single-word array still gets a 1-bit index.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/data_ram_responder_if.sv
// Core <-> data-RAM port. ADDR_ERR exists only when DATA_RAM_ADDR_CHECK_EN is defined.
interface data_ram_responder_if
  import data_ram_pkg::*;
#(
  parameter int SIZE       = DEF_SIZE,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
);
  logic [ADDR_WIDTH-1:0] ADDR_RAM;
  logic [SIZE-1:0]       Q_W;
  logic                  ENABLE_W;
  logic [SIZE-1:0]       Q_RAM;
  logic                  READY;
  logic                  WR_DROP;
  logic [CNT_WIDTH-1:0]  WR_COUNT;
`ifdef DATA_RAM_ADDR_CHECK_EN
  logic                  ADDR_ERR;

  modport master (output ADDR_RAM, Q_W, ENABLE_W,
                  input  Q_RAM, READY, WR_DROP, WR_COUNT, ADDR_ERR);
  modport slave  (input  ADDR_RAM, Q_W, ENABLE_W,
                  output Q_RAM, READY, WR_DROP, WR_COUNT, ADDR_ERR);
`else
  modport master (output ADDR_RAM, Q_W, ENABLE_W,
                  input  Q_RAM, READY, WR_DROP, WR_COUNT);
  modport slave  (input  ADDR_RAM, Q_W, ENABLE_W,
                  output Q_RAM, READY, WR_DROP, WR_COUNT);
`endif
endinterface

// File: rtl/data_ram_responder_sp_sync_ram.sv
// Single-port synchronous RAM: registered read, write-first on the same port.
module sp_sync_ram
  import data_ram_pkg::*;
#(
  parameter int SIZE  = DEF_SIZE,
  parameter int DEPTH = DEF_DEPTH,
  localparam int IDX_W = idx_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             re,
  input  logic [IDX_W-1:0] addr,
  input  logic [SIZE-1:0]  wdata,
  output logic [SIZE-1:0]  rdata
);
  logic [SIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // re low forces the output to zero rather than holding the last read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rdata <= '0;
    else if (!re)  rdata <= '0;
    else if (we)   rdata <= wdata;
    else           rdata <= mem[addr];
  end
endmodule

// File: rtl/data_ram_responder.sv
// Data-RAM responder: zero-fill after reset, then word read/write with store counting.
// Optional DATA_RAM_ADDR_CHECK_EN adds a sticky ADDR_ERR and blocks out-of-range accesses.
module data_ram_responder
  import data_ram_pkg::*;
#(
  parameter int SIZE       = DEF_SIZE,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  data_ram_responder_if.slave  bus
);
  localparam int              IDX_W = idx_width(DEPTH);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  ram_state_t       state;
  logic [IDX_W-1:0] clr_ptr;
  logic [IDX_W-1:0] idx;
  logic             clearing;
  logic             legal;
  logic             commit;
  logic             ram_we;
  logic             ram_re;
  logic [IDX_W-1:0] ram_addr;
  logic [SIZE-1:0]  ram_wdata;

  assign clearing = (state == S_CLEAR);
  // Low index bits only: addresses beyond DEPTH alias modulo DEPTH.
  assign idx      = bus.ADDR_RAM[IDX_W-1:0];

`ifdef DATA_RAM_ADDR_CHECK_EN
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
  assign legal = ({1'b0, bus.ADDR_RAM} < DEPTH_L);
`else
  assign legal = 1'b1;
`endif

  assign commit    = !clearing && bus.ENABLE_W && legal;
  assign ram_we    = clearing || commit;
  assign ram_re    = !clearing && legal;
  assign ram_addr  = clearing ? clr_ptr : idx;
  assign ram_wdata = clearing ? '0 : bus.Q_W;

  sp_sync_ram #(.SIZE(SIZE), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (bus.Q_RAM)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_CLEAR;
      clr_ptr      <= '0;
      bus.READY    <= 1'b0;
      bus.WR_DROP  <= 1'b0;
      bus.WR_COUNT <= '0;
`ifdef DATA_RAM_ADDR_CHECK_EN
      bus.ADDR_ERR <= 1'b0;
`endif
    end else begin
      case (state)
        S_CLEAR: begin
          clr_ptr     <= clr_ptr + 1'b1;
          bus.WR_DROP <= bus.ENABLE_W;
          if (clr_ptr == LAST) begin
            state     <= S_READY;
            bus.READY <= 1'b1;
          end
        end
        S_READY: begin
          bus.WR_DROP <= 1'b0;
          if (commit && (bus.WR_COUNT != {CNT_WIDTH{1'b1}}))
            bus.WR_COUNT <= bus.WR_COUNT + 1'b1;
`ifdef DATA_RAM_ADDR_CHECK_EN
          if (!legal) bus.ADDR_ERR <= 1'b1;
`endif
        end
        default: state <= S_CLEAR;
      endcase
    end
  end
endmodule

// File: tb/tb_data_ram_responder.sv
// Randomized + directed bench for data_ram_responder against an array-based reference model.
module tb_data_ram_responder;
  import data_ram_pkg::*;

  localparam int SIZE       = 32;
  localparam int ADDR_WIDTH = 10;
  localparam int DEPTH      = 16;
  localparam int CNT_WIDTH  = 4;
  localparam int CMAX       = (1 << CNT_WIDTH) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_ram_responder_if #(.SIZE(SIZE), .ADDR_WIDTH(ADDR_WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

  data_ram_responder #(
    .SIZE(SIZE), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // reference model state
  logic [SIZE-1:0] mem [DEPTH];
  int              clr_left;
  logic [SIZE-1:0] eq;
  logic            ey, ed, eerr;
  int              ecnt;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    chk("q_ram",    64'(bus.Q_RAM),    64'(eq));
    chk("ready",    64'(bus.READY),    64'(ey));
    chk("wr_drop",  64'(bus.WR_DROP),  64'(ed));
    chk("wr_count", 64'(bus.WR_COUNT), 64'(ecnt));
`ifdef DATA_RAM_ADDR_CHECK_EN
    chk("addr_err", 64'(bus.ADDR_ERR), 64'(eerr));
`endif
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    clr_left = DEPTH;
    eq = '0; ey = 0; ed = 0; eerr = 0; ecnt = 0;
  endtask

  task automatic model_edge(input logic en, input int a, input logic [SIZE-1:0] d);
    bit legal;
    int i;
    if (clr_left > 0) begin
      ed = en;
      eq = '0;
      clr_left--;
      ey = (clr_left == 0);
    end else begin
      ed = 0;
      legal = 1;
`ifdef DATA_RAM_ADDR_CHECK_EN
      legal = (a < DEPTH);
      if (!legal) eerr = 1;
`endif
      i = a % DEPTH;
      if (!legal) eq = '0;
      else if (en) begin
        mem[i] = d;
        eq = d;
        if (ecnt < CMAX) ecnt++;
      end else eq = mem[i];
    end
  endtask

  task automatic step(input logic en, input int a, input logic [SIZE-1:0] d);
    bus.ENABLE_W = en;
    bus.ADDR_RAM = ADDR_WIDTH'(a);
    bus.Q_W      = d;
    @(posedge clk);
    model_edge(en, a, d);
    #1 check_all();
  endtask

  // Asserted between edges to exercise the asynchronous path.
  task automatic do_reset();
    bus.ENABLE_W = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1 check_all();
    rst = 1'b0;
  endtask

  initial begin
    bus.ENABLE_W = 1'b0;
    bus.ADDR_RAM = '0;
    bus.Q_W      = '0;
    #1;
    do_reset();

    // clear sequence, one store attempt dropped on the 3rd clear cycle
    for (int i = 1; i <= DEPTH; i++) step(i == 3, 4, 32'hCAFE0000 + i);
    for (int a = 0; a < DEPTH; a++) step(1'b0, a, '0);

    step(1'b1, 5, 32'hDEADBEEF);
    step(1'b0, 5, '0);
    step(1'b0, 0, '0);

    step(1'b1, 7, 32'h12345678);
    step(1'b1, 7, 32'h1);
    step(1'b1, 7, 32'h2);
    step(1'b0, 7, '0);
    step(1'b0, 4, '0);

    // address beyond DEPTH
    step(1'b1, DEPTH + 9, 32'h55);
    step(1'b0, 9, '0);
    step(1'b0, DEPTH + 9, '0);

    for (int n = 0; n < 250; n++) begin
      int a;
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023))
                                      : int'($urandom_range(0, DEPTH - 1));
      step(1'($urandom_range(0, 1)), a, $urandom);
    end

    // reset in the middle of operation
    step(1'b1, 2, 32'hA5A5A5A5);
    step(1'b0, 2, '0);
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b0, 2, '0);
    step(1'b0, 2, '0);
    step(1'b1, 3, 32'h0BADF00D);
    step(1'b0, 3, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
